// File: rtl/sram_port_master.sv
// Client-side controller for one SRAM port: single-beat writes, incrementing
// read bursts, 1-cycle read latency tracking and a backpressured response FIFO.
module sram_port_master #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 4,
  parameter int LEN_WIDTH  = 4,
  parameter int RSP_DEPTH  = 2
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         req_valid,
  output logic                         req_ready,
  input  logic                         req_we,
  input  logic [ADDR_WIDTH-1:0]        req_addr,
  input  logic [LEN_WIDTH-1:0]         req_len,
  input  logic signed [DATA_WIDTH-1:0] req_wdata,
  output logic                         rsp_valid,
  input  logic                         rsp_ready,
  output logic signed [DATA_WIDTH-1:0] rsp_rdata,
  output logic [ADDR_WIDTH-1:0]        mem_addr,
  output logic signed [DATA_WIDTH-1:0] mem_data,
  output logic                         mem_we,
  input  logic signed [DATA_WIDTH-1:0] mem_q,
  output logic                         busy
);

  localparam int PW = (RSP_DEPTH > 1) ? $clog2(RSP_DEPTH) : 1;
  localparam int CW = $clog2(RSP_DEPTH + 1);

  typedef enum logic [1:0] {
    IDLE,
    WR,
    RD
  } state_t;

  state_t                       state;
  logic [LEN_WIDTH-1:0]         rem;
  logic                         in_flight;
  logic signed [DATA_WIDTH-1:0] fifo [RSP_DEPTH];
  logic [PW-1:0]                wr_ptr;
  logic [PW-1:0]                rd_ptr;
  logic [CW-1:0]                count;
  logic [CW:0]                  occ;
  logic                         pop;
  logic                         push;
  logic                         issue;

  function automatic logic [PW-1:0] nxt(input logic [PW-1:0] p);
    return (p == PW'(RSP_DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  assign req_ready = (state == IDLE);
  assign rsp_valid = (count != '0);
  assign rsp_rdata = fifo[rd_ptr];
  assign pop       = rsp_valid && rsp_ready;
  assign push      = in_flight;
  assign busy      = (state != IDLE) || in_flight || rsp_valid;

  // Occupancy seen after this cycle's pop, counting the beat still in flight.
  assign occ   = (CW+1)'(count) - (CW+1)'(pop) + (CW+1)'(in_flight);
  assign issue = (state == RD) && (occ < (CW+1)'(RSP_DEPTH));

  // mem_addr holds the address the SRAM samples at the coming edge;
  // a stalled beat simply keeps it in place.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_data  <= '0;
      rem       <= '0;
      in_flight <= 1'b0;
    end else begin
      in_flight <= issue;
      unique case (state)
        IDLE: begin
          if (req_valid) begin
            mem_addr <= req_addr;
            if (req_we) begin
              mem_data <= req_wdata;
              mem_we   <= 1'b1;
              state    <= WR;
            end else begin
              rem   <= req_len;
              state <= RD;
            end
          end
        end
        WR: begin
          mem_we <= 1'b0;
          state  <= IDLE;
        end
        RD: begin
          if (issue) begin
            if (rem == '0) begin
              state <= IDLE;
            end else begin
              rem      <= rem - LEN_WIDTH'(1);
              mem_addr <= mem_addr + ADDR_WIDTH'(1);
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < RSP_DEPTH; i++) fifo[i] <= '0;
    end else begin
      if (push) begin
        fifo[wr_ptr] <= mem_q;
        wr_ptr       <= nxt(wr_ptr);
      end
      if (pop) rd_ptr <= nxt(rd_ptr);
      count <= count + CW'(push) - CW'(pop);
    end
  end

endmodule

// File: tb/tb_sram_port_master.sv
// Bench for sram_port_master: SRAM model, shadow memory and expected-beat
// queue; read data is compared at every response handshake.
module tb_sram_port_master;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              req_valid;
  logic              req_ready;
  logic              req_we;
  logic [3:0]        req_addr;
  logic [3:0]        req_len;
  logic signed [31:0] req_wdata;
  logic              rsp_valid;
  logic              rsp_ready;
  logic signed [31:0] rsp_rdata;
  logic [3:0]        mem_addr;
  logic signed [31:0] mem_data;
  logic              mem_we;
  logic signed [31:0] mem_q;
  logic              busy;

  int checks = 0;
  int errors = 0;

  logic [31:0] sram    [16];
  logic [31:0] ref_mem [16];
  logic [31:0] exp_q [$];
  logic [31:0] last_pop;
  logic        prev_we;
  int          rmode;
  int          pi;
  logic [5:0]  pat;

  always #5 clk = ~clk;

  sram_port_master dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_we    (req_we),
    .req_addr  (req_addr),
    .req_len   (req_len),
    .req_wdata (req_wdata),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_rdata (rsp_rdata),
    .mem_addr  (mem_addr),
    .mem_data  (mem_data),
    .mem_we    (mem_we),
    .mem_q     (mem_q),
    .busy      (busy)
  );

  // SRAM port: registered read of old contents, write on we.
  always @(posedge clk) begin
    if (mem_we) sram[mem_addr] <= mem_data;
    mem_q <= sram[mem_addr];
  end

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  always @(posedge clk) begin
    #1;
    case (rmode)
      0:       rsp_ready = 1'b1;
      1:       rsp_ready = 1'($urandom_range(0, 1));
      default: rsp_ready = pat[5 - (pi % 6)];
    endcase
    pi++;
  end

  always @(negedge clk) begin
    if (rst_n && rsp_valid && rsp_ready) begin
      if (exp_q.size() == 0) begin
        chk("spurious_beat", 32'd1, 32'd0);
      end else begin
        last_pop = rsp_rdata;
        chk("rsp_data", rsp_rdata, exp_q.pop_front());
      end
    end
  end

  always @(negedge clk) begin
    if (rst_n && mem_we) chk("we_pulse", {31'd0, prev_we}, 32'd0);
    prev_we = rst_n ? mem_we : 1'b0;
  end

  task automatic wait_ready();
    int n = 0;
    while (!req_ready && n < 100) begin
      @(posedge clk); #1; n++;
    end
    if (n >= 100) chk("req_timeout", 32'd1, 32'd0);
  endtask

  task automatic wr(input int a, input logic [31:0] d);
    req_valid = 1'b1; req_we = 1'b1;
    req_addr = 4'(a); req_wdata = d; req_len = 4'($urandom);
    wait_ready();
    @(posedge clk);
    ref_mem[a % 16] = d;
    #1 req_valid = 1'b0;
  endtask

  task automatic rd(input int a, input int len);
    req_valid = 1'b1; req_we = 1'b0;
    req_addr = 4'(a); req_len = 4'(len); req_wdata = $urandom;
    wait_ready();
    @(posedge clk);
    for (int i = 0; i <= len; i++) exp_q.push_back(ref_mem[(a + i) % 16]);
    #1 req_valid = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while ((exp_q.size() != 0 || busy) && n < 400) begin
      @(negedge clk); n++;
    end
    chk("drain", {31'd0, n < 400}, 32'd1);
  endtask

  initial begin
    logic [31:0] d;
    rst_n = 1'b0; req_valid = 1'b0; req_we = 1'b0;
    req_addr = '0; req_len = '0; req_wdata = '0;
    rsp_ready = 1'b1; rmode = 0; pi = 0; pat = 6'b100101;
    prev_we = 1'b0;
    for (int i = 0; i < 16; i++) begin
      sram[i] = $urandom;
      ref_mem[i] = sram[i];
    end
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_req_ready", {31'd0, req_ready}, 32'd1);
    chk("rst_mem_we", {31'd0, mem_we}, 32'd0);
    chk("rst_mem_addr", {28'd0, mem_addr}, 32'd0);
    chk("rst_mem_data", mem_data, 32'd0);
    chk("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    chk("rst_rsp_rdata", rsp_rdata, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    rst_n = 1'b1;

    // single write
    @(posedge clk); #1;
    req_valid = 1'b1; req_we = 1'b1; req_addr = 4'd4;
    req_wdata = 32'h1234_5678;
    @(negedge clk);
    chk("wr_accept_ready", {31'd0, req_ready}, 32'd1);
    @(posedge clk);
    ref_mem[4] = 32'h1234_5678;
    #1 req_valid = 1'b0;
    @(negedge clk);
    chk("wr_mem_we", {31'd0, mem_we}, 32'd1);
    chk("wr_mem_addr", {28'd0, mem_addr}, 32'd4);
    chk("wr_mem_data", mem_data, 32'h1234_5678);
    @(negedge clk);
    chk("wr_we_drop", {31'd0, mem_we}, 32'd0);
    chk("wr_busy_idle", {31'd0, busy}, 32'd0);

    // writes then single reads, latency check
    for (int i = 0; i < 4; i++) wr(i * 4, $urandom);
    for (int i = 0; i < 4; i++) begin
      rd(i * 4, 0);
      @(negedge clk); @(negedge clk);
      chk("rd_lat_early", {31'd0, rsp_valid}, 32'd0);
      @(negedge clk);
      chk("rd_lat_valid", {31'd0, rsp_valid}, 32'd1);
      drain();
    end

    // wrapping burst at full throughput
    rd(14, 3);
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (i < 4) chk("burst_addr", {28'd0, mem_addr}, 32'((14 + i) % 16));
      if (i >= 2) chk("burst_b2b", {31'd0, rsp_valid}, 32'd1);
    end
    drain();

    // patterned backpressure
    rmode = 2; pi = 0;
    rd(5, 7);
    drain();
    rmode = 1;
    rd(9, 7);
    drain();

    // read after write
    rmode = 0;
    wr(3, 32'hDEAD_BEEF);
    rd(3, 0);
    drain();
    chk("raw_data", last_pop, 32'hDEAD_BEEF);

    // reset while mem_we is high: the write must never land
    req_valid = 1'b1; req_we = 1'b1; req_addr = 4'd9; req_wdata = 32'hA5A5_0001;
    wait_ready();
    @(posedge clk); #1 req_valid = 1'b0;
    @(negedge clk);
    chk("pre_rst_we", {31'd0, mem_we}, 32'd1);
    #1 rst_n = 1'b0;
    #1;
    chk("async_we", {31'd0, mem_we}, 32'd0);
    chk("async_busy", {31'd0, busy}, 32'd0);
    @(negedge clk) rst_n = 1'b1;

    // reset mid-burst on the third of eight beats
    rd(0, 7);
    repeat (3) @(negedge clk);
    #1 rst_n = 1'b0;
    exp_q.delete();
    #1;
    chk("mid_rst_addr", {28'd0, mem_addr}, 32'd0);
    chk("mid_rst_data", mem_data, 32'd0);
    chk("mid_rst_rsp", {31'd0, rsp_valid}, 32'd0);
    chk("mid_rst_rdata", rsp_rdata, 32'd0);
    chk("mid_rst_busy", {31'd0, busy}, 32'd0);
    chk("mid_rst_ready", {31'd0, req_ready}, 32'd1);
    @(negedge clk) rst_n = 1'b1;
    @(negedge clk);
    chk("post_rst_ready", {31'd0, req_ready}, 32'd1);
    rd(9, 1);
    drain();

    // random mix under random backpressure
    rmode = 1;
    for (int k = 0; k < 40; k++) begin
      if ($urandom_range(0, 2) == 0) begin
        d = $urandom;
        wr($urandom_range(0, 15), d);
      end else begin
        rd($urandom_range(0, 15), $urandom_range(0, 15));
      end
    end
    drain();
    chk("end_idle", {31'd0, busy}, 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL global_timeout");
    $fatal(1, "timeout");
  end

endmodule
